// File: rtl/colour_sequence_player_if.sv
// Write channel of the colour sequence player: one colour code per valid/ready handshake.
interface colour_sequence_player_if #(
  parameter int NUM_COLOURS = 4
);
  localparam int CODE_W = (NUM_COLOURS > 1) ? $clog2(NUM_COLOURS) : 1;

  logic              wr_valid;
  logic              wr_ready;
  logic [CODE_W-1:0] wr_colour;

  modport master (output wr_valid, output wr_colour, input wr_ready);
  modport slave  (input wr_valid, input wr_colour, output wr_ready);
endinterface

// File: rtl/colour_sequence_player.sv
// Buffers colour codes and replays them on one-hot lamps with programmable on-time and gap.
// Define COLOUR_SEQ_LOOP_EN to add loop_i, which keeps replaying the sequence until it drops.
module colour_sequence_player #(
  parameter int NUM_COLOURS = 4,
  parameter int DEPTH       = 8,
  parameter int ON_CYCLES   = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           oe_i,
  input  logic                           start_i,
  input  logic                           clear_i,
`ifdef COLOUR_SEQ_LOOP_EN
  input  logic                           loop_i,
`endif
  colour_sequence_player_if.slave        wr,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o,
  output logic [NUM_COLOURS-1:0]         lamp_o
);

  localparam int CODE_W = (NUM_COLOURS > 1) ? $clog2(NUM_COLOURS) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int MAX_T  = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int TMR_W  = $clog2(MAX_T + 1);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [CNT_W-1:0]       index_q, index_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [NUM_COLOURS-1:0] lamp_q, lamp_d;
  logic                   done_q, done_d;
  logic [CODE_W-1:0]      mem_q [DEPTH];

  logic                   wr_fire;
  logic                   last_entry;
  logic                   loop_on;
  logic [CODE_W-1:0]      show_code;

  assign wr.wr_ready = (state_q == IDLE) && (count_q < CNT_W'(DEPTH)) && !clear_i;
  assign wr_fire     = wr.wr_valid && wr.wr_ready;
  assign last_entry  = (index_q == count_q - CNT_W'(1));

`ifdef COLOUR_SEQ_LOOP_EN
  assign loop_on = loop_i;
`else
  assign loop_on = 1'b0;
`endif

  // Entries are never consumed, so replay just walks the buffer again from index 0.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[count_q[IDX_W-1:0]] <= wr.wr_colour;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      index_q <= '0;
      timer_q <= '0;
      lamp_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      index_q <= index_d;
      timer_q <= timer_d;
      lamp_q  <= lamp_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    index_d = index_q;
    timer_d = timer_q;
    done_d  = 1'b0;

    if (wr_fire) begin
      count_d = count_q + CNT_W'(1);
    end

    // A write accepted alongside start is already counted, so it joins this playback.
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (count_d != '0) begin
            state_d = SHOW;
            index_d = '0;
            timer_d = TMR_W'(ON_CYCLES - 1);
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SHOW: begin
        if (timer_q == '0) begin
          if (last_entry && !loop_on) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = GAP;
            timer_d = TMR_W'(GAP_CYCLES - 1);
          end
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      GAP: begin
        if (timer_q == '0) begin
          state_d = SHOW;
          index_d = last_entry ? '0 : index_q + CNT_W'(1);
          timer_d = TMR_W'(ON_CYCLES - 1);
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (clear_i) begin
      state_d = IDLE;
      count_d = '0;
      index_d = '0;
      timer_d = '0;
      done_d  = 1'b0;
    end
  end

  // The entry written this very cycle is not in mem_q yet, so bypass it for the first slot.
  always_comb begin
    show_code = mem_q[index_d[IDX_W-1:0]];
    if (wr_fire && (index_d == count_q)) begin
      show_code = wr.wr_colour;
    end
    lamp_d = '0;
    if ((state_d == SHOW) && oe_i) begin
      for (int k = 0; k < NUM_COLOURS; k++) begin
        lamp_d[k] = (show_code == CODE_W'(k));
      end
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign done_o  = done_q;
  assign count_o = count_q;
  assign lamp_o  = lamp_q;

endmodule

// File: tb/tb_colour_sequence_player.sv
// Scoreboard bench for colour_sequence_player: stimulus pushes the expected per-cycle lamp trace,
// a negedge monitor pops and compares whenever the player is active.
module tb_colour_sequence_player;
  localparam int NC    = 4;
  localparam int DEPTH = 8;
  localparam int ON    = 4;
  localparam int GAP   = 2;

  typedef struct packed {
    logic [NC-1:0] lamp;
    logic          busy;
    logic          done;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          oe;
  logic          start;
  logic          clear;
  logic          loop;
  logic          busy;
  logic          done;
  logic [3:0]    count;
  logic [NC-1:0] lamp;

  obs_t expQ[$];
  int   refBuf[$];
  int   total = 0;
  int   bad = 0;
  bit   monActive = 1'b0;
  obs_t actObs;
  obs_t expObs;

  colour_sequence_player_if #(.NUM_COLOURS(NC)) wrIf();

  colour_sequence_player #(
    .NUM_COLOURS(NC), .DEPTH(DEPTH), .ON_CYCLES(ON), .GAP_CYCLES(GAP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .oe_i    (oe),
    .start_i (start),
    .clear_i (clear),
`ifdef COLOUR_SEQ_LOOP_EN
    .loop_i  (loop),
`endif
    .wr      (wrIf.slave),
    .busy_o  (busy),
    .done_o  (done),
    .count_o (count),
    .lamp_o  (lamp)
  );

  always #5 clk = ~clk;

  function automatic obs_t mkObs(input logic [NC-1:0] l, input logic b, input logic d);
    obs_t o;
    o.lamp = l;
    o.busy = b;
    o.done = d;
    return o;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: any active cycle must match the next expected trace entry.
  initial begin
    forever begin
      @(negedge clk);
      if (monActive && !rst && (busy || done || lamp != '0)) begin
        actObs = mkObs(lamp, busy, done);
        total++;
        if (expQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL trace: got lamp=%b busy=%b done=%b, expected idle", lamp, busy, done);
        end else begin
          expObs = expQ.pop_front();
          if (actObs !== expObs) begin
            bad++;
            $display("[TB] FAIL trace: got lamp=%b busy=%b done=%b, expected lamp=%b busy=%b done=%b",
                     actObs.lamp, actObs.busy, actObs.done, expObs.lamp, expObs.busy, expObs.done);
          end
        end
      end
    end
  end

  task automatic writeCode(input int c);
    bit expAcc;
    expAcc = (refBuf.size() < DEPTH);
    wrIf.wr_valid  = 1'b1;
    wrIf.wr_colour = 2'(c);
    #1;
    checkOutput("wr_ready", 32'(wrIf.wr_ready), 32'(expAcc));
    tick();
    if (expAcc) refBuf.push_back(c);
    wrIf.wr_valid = 1'b0;
  endtask

  task automatic clearBuf();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    refBuf.delete();
  endtask

  // clearAt: -1 none, -2 random point, otherwise the step at which clear is driven.
  task automatic applyStimulus(input int clearAt, input bit withWrite, input int wcode,
                               input bit randOe, input bit startMid);
    int   n;
    int   len;
    int   clr;
    int   j;
    bit   oeS[$];
    obs_t rec[$];
    bit   doWrite;

    doWrite = withWrite && (refBuf.size() < DEPTH);
    if (doWrite) refBuf.push_back(wcode);
    n   = refBuf.size();
    len = (n == 0) ? 1 : n * ON + (n - 1) * GAP + 1;
    for (int k = 0; k < len; k++) oeS.push_back(randOe ? ($urandom_range(0, 3) != 0) : 1'b1);

    j = 0;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < ON; k++) begin
        rec.push_back(mkObs(oeS[j] ? NC'(1 << refBuf[i]) : '0, 1'b1, 1'b0));
        j++;
      end
      if (i < n - 1) begin
        for (int k = 0; k < GAP; k++) begin
          rec.push_back(mkObs('0, 1'b1, 1'b0));
          j++;
        end
      end
    end
    rec.push_back(mkObs('0, 1'b0, 1'b1));

    clr = clearAt;
    if (clr == -2) clr = (len >= 3) ? $urandom_range(1, len - 2) : -1;
    if (clr > 0) begin
      while (rec.size() > clr) void'(rec.pop_back());
    end
    foreach (rec[k]) expQ.push_back(rec[k]);

    for (int s = 0; s < len; s++) begin
      oe    = oeS[s];
      start = (s == 0) || (startMid && s == len / 2);
      clear = (s == clr);
      if (s == 0) begin
        wrIf.wr_valid  = doWrite;
        wrIf.wr_colour = 2'(wcode);
      end else begin
        wrIf.wr_valid  = startMid && (s <= len - 2);
        wrIf.wr_colour = 2'($urandom_range(0, 3));
      end
      tick();
      if (s == clr) break;
    end
    if (clr > 0) refBuf.delete();
    start = 1'b0;
    clear = 1'b0;
    oe    = 1'b1;
    wrIf.wr_valid = 1'b0;
    repeat (3) tick();
    checkOutput("drain", 32'(expQ.size()), 32'd0);
    checkOutput("count", 32'(count), 32'(refBuf.size()));
    expQ.delete();
  endtask

  initial begin
    rst = 1'b1;
    oe = 1'b1;
    start = 1'b0;
    clear = 1'b0;
    loop = 1'b0;
    wrIf.wr_valid = 1'b0;
    wrIf.wr_colour = '0;
    #12;
    checkOutput("reset_lamp", 32'(lamp), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_count", 32'(count), 32'd0);
    tick();
    rst = 1'b0;
    monActive = 1'b1;
    tick();

    writeCode(2);
    writeCode(0);
    writeCode(3);
    applyStimulus(-1, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(-1, 1'b0, 0, 1'b0, 1'b1);
    applyStimulus(11, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(-1, 1'b0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 9; i++) writeCode($urandom_range(0, 3));
    checkOutput("full_count", 32'(count), 32'd8);
    checkOutput("full_ready", 32'(wrIf.wr_ready), 32'd0);
    applyStimulus(-1, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(-1, 1'b0, 0, 1'b0, 1'b0);

    clearBuf();
    writeCode(1);
    writeCode(3);
    applyStimulus(-1, 1'b1, 2, 1'b1, 1'b0);

    for (int r = 0; r < 12; r++) begin
      clearBuf();
      repeat ($urandom_range(0, 9)) writeCode($urandom_range(0, 3));
      applyStimulus(($urandom_range(0, 2) == 0) ? -2 : -1, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), 1'b1, 1'($urandom_range(0, 1)));
    end

    clearBuf();
    writeCode(1);
    writeCode(2);
    monActive = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checkOutput("pre_reset_lamp", 32'(lamp), 32'h2);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_reset_lamp", 32'(lamp), 32'd0);
    checkOutput("mid_reset_busy", 32'(busy), 32'd0);
    checkOutput("mid_reset_count", 32'(count), 32'd0);
    tick();
    rst = 1'b0;
    refBuf.delete();
    expQ.delete();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/colour_sequence_player.md
Name: colour_sequence_player

Overview:
Parametrised successor to the 4-colour one-hot lamp encoder. Buffers a sequence of colour codes written over a valid/ready port, then plays it back on one-hot lamp outputs with programmable on-time and gap. Sits between game/control logic and the uo lamp pins. Provides busy/done status to the controller.

Parameters:
NUM_COLOURS, 4, number of lamps / valid colour codes (2..16); CODE_W = clog2(NUM_COLOURS) as a derived localparam.
DEPTH, 8, sequence buffer entries (power of 2, 2..32); CNT_W = clog2(DEPTH+1) as a derived localparam.
ON_CYCLES, 4, clock cycles each colour lamp is lit (>=1).
GAP_CYCLES, 2, dark cycles between consecutive colours (>=1).

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous, active-high reset
oe  in  1  lamp output enable, active high
wr_valid  in  1  write request for one colour code
wr_ready  out  1  buffer accepts a write this cycle
wr_colour  in  CODE_W  colour code; code k lights lamp[k]
start  in  1  single-cycle request to begin playback
clear  in  1  empty buffer / abort playback
busy  out  1  playback in progress
done  out  1  one-cycle pulse at end of playback
count  out  CNT_W  entries currently stored
lamp  out  NUM_COLOURS  registered one-hot lamp drive

Behaviour:
- Reset (async): state IDLE, count=0, index=0, timer=0, lamp=0, busy=0, done=0. The buffer RAM contents are don't-care.
- wr_ready = (state==IDLE) && (count<DEPTH) && !clear. A write occurs when wr_valid && wr_ready: buf[count] <= wr_colour, count++. When full (count==DEPTH), writes are blocked and the buffer is unchanged.
- Playback does not consume entries. The sequence can be replayed by issuing start again.
- States: IDLE, SHOW, GAP.
- IDLE: start=1 with count>0 -> SHOW, index=0, timer=ON_CYCLES-1.
- IDLE: start=1 with count==0 -> stay IDLE; done=1 on the next cycle; lamp stays 0.
- Simultaneous start and an accepted write in IDLE: both take effect. Playback includes the new entry.
- SHOW: lamp = onehot(buf[index]) gated by oe. Timer decrements each cycle. At timer==0: if index==count-1, go to IDLE and assert done for one cycle. Otherwise go to GAP with timer=GAP_CYCLES-1.
- GAP: lamp=0. At timer==0: go to SHOW, index++, timer=ON_CYCLES-1.
- busy=1 whenever state != IDLE.
- Latency: start sampled at edge t -> lamp valid from cycle t+1. Each entry shows for exactly ON_CYCLES cycles and is followed by GAP_CYCLES dark cycles, except after the last entry. done is high in the first IDLE cycle after the last SHOW. Total busy cycles = count*ON_CYCLES + (count-1)*GAP_CYCLES.
- Codes >= NUM_COLOURS, possible only when NUM_COLOURS is not a power of 2: lamp all zero for that slot. Timing is unchanged.
- oe=0: lamp forced to 0 at the register input (next cycle). Sequencing, timers and done are unaffected. There is no tristate inside the block.
- start while busy: ignored.
- clear (any state): next cycle state=IDLE, count=0, index=0, lamp=0, done=0. clear has priority over start and write in the same cycle. clear during playback gives no done pulse.
- At most one lamp bit is high in any cycle.

Optional Feature:
COLOUR_SEQ_LOOP_EN. When defined, an extra input port loop (1 bit) exists. At the end of the last SHOW with loop=1, the block enters GAP and then restarts at index 0. No done pulse is generated and busy stays 1. Playback continues until loop is sampled 0 at the end of the last entry (normal finish with done) or until clear. When not defined, the port is absent and playback always finishes after one pass.

Test Plan:
- Reset mid-playback: assert rst during SHOW -> same cycle lamp=0, busy=0, count=0.
- Write codes 2,0,3 then start with oe=1 -> lamp=4'b0100 for 4 cycles, 0 for 2, 4'b0001 for 4, 0 for 2, 4'b1000 for 4. Then done=1 for one cycle, busy high for exactly 16 cycles, count stays 3.
- Write 8 entries -> wr_ready=0 and count=8. A 9th wr_valid is not accepted. Replay via a second start shows an identical lamp trace.
- start with count=0 -> done pulse the next cycle, busy never asserts, lamp stays 0. start during busy is ignored, so the trace is unchanged.
- clear asserted in the 2nd GAP of a 3-entry playback -> next cycle IDLE, lamp=0, count=0, no done pulse. oe=0 during playback gives lamp=0 while done still pulses at the same cycle.
- With COLOUR_SEQ_LOOP_EN and loop=1 on a 2-entry sequence [1,3] -> 0010,gap,1000,gap,0010,... Dropping loop before the final 1000 ends with done after it.
